// File: rtl/fib_pkg.sv
// -----------------------------------------------------------------------------
// fib_pkg
//   Shared definitions for the Fibonacci register-file master.
//   - state_t        : master FSM states
//   - DATA_W_DEF     : default register data width
//   - ADDR_W_DEF     : default register address width (32 entries)
//   - FIRST_FILL_IDX : first register written by a fill; reg[0] and reg[1]
//                      are the seeds provided by the register file
// -----------------------------------------------------------------------------
package fib_pkg;

  localparam int DATA_W_DEF     = 32;
  localparam int ADDR_W_DEF     = 5;
  localparam int FIRST_FILL_IDX = 2;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    HWR  = 3'd1,
    HRD  = 3'd2,
    FRD  = 3'd3,
    FWR  = 3'd4,
    DONE = 3'd5
  } state_t;

endpackage

// File: rtl/fib_adder.sv
// -----------------------------------------------------------------------------
// fib_adder
//   Unsigned DATA_W-bit adder producing the next Fibonacci term.
//   The sum is formed at DATA_W+1 bits; carry reports the overflow bit.
//
//   Build option: FIB_SAT_EN
//     defined   : on carry-out, sum is clamped to all ones
//     undefined : sum wraps modulo 2^DATA_W
//
//   Ports
//     a, b   in  DATA_W  operands (register file read data)
//     sum    out DATA_W  result presented as register write data
//     carry  out 1       carry-out of the full-width add
// -----------------------------------------------------------------------------
module fib_adder
  import fib_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] sum,
  output logic              carry
);

  logic [DATA_W:0] raw_sum;

  assign raw_sum = {1'b0, a} + {1'b0, b};
  assign carry   = raw_sum[DATA_W];

`ifdef FIB_SAT_EN
  function automatic logic [DATA_W-1:0] sat_word(input logic [DATA_W:0] s);
    logic [DATA_W-1:0] r;
    if (s[DATA_W]) r = '1;
    else           r = s[DATA_W-1:0];
    return r;
  endfunction

  assign sum = sat_word(raw_sum);
`else
  assign sum = raw_sum[DATA_W-1:0];
`endif

endmodule

// File: rtl/fib_regfile_master.sv
// -----------------------------------------------------------------------------
// fib_regfile_master
//   Initiator for a 2-read/1-write register file. Fills
//   reg[i] = reg[i-2] + reg[i-1] for i = 2..n_last (two cycles per register:
//   FRD presents read addresses, FWR writes the sum), and offers a host
//   single-word write and a host readback while idle.
//
//   Build option: FIB_SAT_EN (saturating sum and sticky sat flag);
//   when undefined the sum wraps and sat is tied low.
//
//   Ports
//     clk, rst_n         clock, asynchronous active-low reset
//     start, n_last      begin a fill up to reg[n_last] (IDLE only)
//     wr_req/addr/data   host write (IDLE only)
//     rd_req, rd_addr    host readback (IDLE only)
//     rd_data, rd_valid  readback result, rd_valid pulses one cycle
//     busy               high whenever the FSM is not in IDLE
//     done               one-cycle pulse at end of a fill
//     last_value         value written to reg[n_last] by the last fill
//     sat                sticky saturation flag
//     r1_addr, r2_addr   register file read addresses (registered)
//     r3_addr, r3_din,
//     r3_wr              register file write port
//     r1_dout, r2_dout   register file read data (updated on negedge clk)
// -----------------------------------------------------------------------------
module fib_regfile_master
  import fib_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] n_last,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] last_value,
  output logic              sat,
  output logic [ADDR_W-1:0] r1_addr,
  output logic [ADDR_W-1:0] r2_addr,
  output logic [ADDR_W-1:0] r3_addr,
  output logic [DATA_W-1:0] r3_din,
  output logic              r3_wr,
  input  logic [DATA_W-1:0] r1_dout,
  input  logic [DATA_W-1:0] r2_dout
);

  localparam logic [ADDR_W-1:0] FIRST_IDX = ADDR_W'(FIRST_FILL_IDX);
  localparam logic [ADDR_W-1:0] SEED0_IDX = ADDR_W'(FIRST_FILL_IDX - 2);
  localparam logic [ADDR_W-1:0] SEED1_IDX = ADDR_W'(FIRST_FILL_IDX - 1);

  state_t            state;
  logic [ADDR_W-1:0] idx;
  logic [ADDR_W-1:0] n_last_q;
  logic [DATA_W-1:0] wr_data_q;
  logic [DATA_W-1:0] add_sum;
  logic              add_carry;
  logic              host_wr_accept;

  fib_adder #(
    .DATA_W (DATA_W)
  ) u_adder (
    .a     (r1_dout),
    .b     (r2_dout),
    .sum   (add_sum),
    .carry (add_carry)
  );

`ifdef FIB_SAT_EN
  logic sat_q;
  assign sat = sat_q;
`else
  logic add_carry_unused;
  assign add_carry_unused = add_carry;
  assign sat = 1'b0;
`endif

  // A host write is taken only when nothing of higher priority is pending.
  assign host_wr_accept = (state == IDLE) && !start && wr_req;

  // Write data source: adder during a fill, latched host word during HWR.
  // Forced to zero whenever no write is in progress.
  always_comb begin
    r3_din = '0;
    if (r3_wr) begin
      if (state == FWR) r3_din = add_sum;
      else              r3_din = wr_data_q;
    end
  end

  // Host write data is only consumed in HWR, so it needs no reset.
  always_ff @(posedge clk) begin
    if (host_wr_accept) wr_data_q <= wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      idx        <= '0;
      n_last_q   <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      rd_valid   <= 1'b0;
      rd_data    <= '0;
      last_value <= '0;
      r1_addr    <= '0;
      r2_addr    <= '0;
      r3_addr    <= '0;
      r3_wr      <= 1'b0;
`ifdef FIB_SAT_EN
      sat_q      <= 1'b0;
`endif
    end else begin
      done     <= 1'b0;
      rd_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            busy <= 1'b1;
`ifdef FIB_SAT_EN
            sat_q <= 1'b0;
`endif
            if (n_last < FIRST_IDX) begin
              // Nothing to fill: the seeds already cover reg[0..n_last].
              done  <= 1'b1;
              state <= DONE;
            end else begin
              n_last_q <= n_last;
              idx      <= FIRST_IDX;
              r1_addr  <= SEED0_IDX;
              r2_addr  <= SEED1_IDX;
              r3_wr    <= 1'b0;
              state    <= FRD;
            end
          end else if (wr_req) begin
            busy    <= 1'b1;
            r3_addr <= wr_addr;
            r3_wr   <= 1'b1;
            state   <= HWR;
          end else if (rd_req) begin
            busy    <= 1'b1;
            r1_addr <= rd_addr;
            state   <= HRD;
          end
        end
        HWR: begin
          r3_wr <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        HRD: begin
          // r1_dout was refreshed on the negedge inside HRD.
          rd_data  <= r1_dout;
          rd_valid <= 1'b1;
          busy     <= 1'b0;
          state    <= IDLE;
        end
        FRD: begin
          r3_addr <= idx;
          r3_wr   <= 1'b1;
          state   <= FWR;
        end
        FWR: begin
          r3_wr <= 1'b0;
`ifdef FIB_SAT_EN
          if (add_carry) sat_q <= 1'b1;
`endif
          if (idx == n_last_q) begin
            last_value <= add_sum;
            done       <= 1'b1;
            state      <= DONE;
          end else begin
            // Next term reads the two most recent registers; reg[idx] is
            // written at this edge, ahead of the negedge read capture.
            r1_addr <= idx - 1'b1;
            r2_addr <= idx;
            idx     <= idx + 1'b1;
            state   <= FRD;
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          r3_wr <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fib_regfile_master.sv
module tb_fib_regfile_master;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [4:0]  n_last = '0;
  logic        wr_req = 1'b0;
  logic [4:0]  wr_addr = '0;
  logic [31:0] wr_data = '0;
  logic        rd_req = 1'b0;
  logic [4:0]  rd_addr = '0;
  logic [31:0] rd_data;
  logic        rd_valid;
  logic        busy;
  logic        done;
  logic [31:0] last_value;
  logic        sat;
  logic [4:0]  r1_addr, r2_addr, r3_addr;
  logic [31:0] r3_din;
  logic        r3_wr;
  logic [31:0] r1_dout = '0;
  logic [31:0] r2_dout = '0;

  int checks = 0;
  int errors = 0;

  logic [31:0] mem [32];
  logic [31:0] ref_mem [32];
  logic [36:0] wq [$];
  logic [31:0] exp_last = '0;
  logic        exp_sat = 1'b0;

  always #5 clk = ~clk;

  fib_regfile_master #(.DATA_W(32), .ADDR_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .n_last(n_last),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid),
    .busy(busy), .done(done), .last_value(last_value), .sat(sat),
    .r1_addr(r1_addr), .r2_addr(r2_addr), .r3_addr(r3_addr),
    .r3_din(r3_din), .r3_wr(r3_wr), .r1_dout(r1_dout), .r2_dout(r2_dout)
  );

  // Register file model: seeds on reset, writes on posedge, reads on negedge.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int j = 0; j < 32; j++) mem[j] <= '0;
      mem[0] <= 32'd1;
      mem[1] <= 32'd1;
    end else if (r3_wr) begin
      mem[r3_addr] <= r3_din;
    end
  end

  always @(negedge clk) begin
    r1_dout <= mem[r1_addr];
    r2_dout <= mem[r2_addr];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Scoreboard consumer: every write strobe must match the next expected write.
  always @(negedge clk) begin
    if (rst_n && r3_wr) begin
      if (wq.size() == 0) begin
        chk("unexpected_write_addr", {27'd0, r3_addr}, 32'hFFFF_FFFF);
      end else begin
        logic [36:0] e;
        e = wq.pop_front();
        chk("write_addr", {27'd0, r3_addr}, {27'd0, e[36:32]});
        chk("write_data", r3_din, e[31:0]);
      end
    end
  end

  task automatic reseed_ref();
    for (int j = 0; j < 32; j++) ref_mem[j] = '0;
    ref_mem[0] = 32'd1;
    ref_mem[1] = 32'd1;
  endtask

  task automatic ref_fill(input int n);
    logic [32:0] s;
    logic [31:0] w;
    for (int i = 2; i <= n; i++) begin
      s = {1'b0, ref_mem[i-2]} + {1'b0, ref_mem[i-1]};
`ifdef FIB_SAT_EN
      w = s[32] ? 32'hFFFF_FFFF : s[31:0];
      if (s[32]) exp_sat = 1'b1;
`else
      w = s[31:0];
`endif
      ref_mem[i] = w;
      wq.push_back({5'(i), w});
      exp_last = w;
    end
  endtask

  task automatic do_fill(input int n, input bit disturb);
    int cycles;
    int exp_cyc;
    exp_sat = 1'b0;
    ref_fill(n);
    exp_cyc = (n < 2) ? 1 : 1 + 2 * (n - 1);
    start = 1'b1;
    n_last = 5'(n);
    @(posedge clk); #1;
    start = 1'b0;
    cycles = 1;
    while (done !== 1'b1 && cycles < 200) begin
      @(posedge clk); #1;
      cycles++;
      if (disturb && cycles == 10) begin
        start = 1'b1; n_last = 5'd3;
        wr_req = 1'b1; wr_addr = 5'd4; wr_data = 32'h0000_DEAD;
        rd_req = 1'b1; rd_addr = 5'd0;
      end else begin
        start = 1'b0; wr_req = 1'b0; rd_req = 1'b0;
      end
    end
    chk($sformatf("done_latency_n%0d", n), 32'(cycles), 32'(exp_cyc));
    chk("busy_at_done", {31'd0, busy}, 32'd1);
    chk("last_value", last_value, exp_last);
    @(posedge clk); #1;
    chk("done_one_cycle", {31'd0, done}, 32'd0);
    chk("busy_after_done", {31'd0, busy}, 32'd0);
    chk("sat_flag", {31'd0, sat}, {31'd0, exp_sat});
    chk("all_writes_seen", 32'(wq.size()), 32'd0);
  endtask

  task automatic host_wr(input logic [4:0] a, input logic [31:0] d);
    wq.push_back({a, d});
    ref_mem[a] = d;
    wr_req = 1'b1; wr_addr = a; wr_data = d;
    @(posedge clk); #1;
    wr_req = 1'b0;
    @(posedge clk); #1;
    chk("host_wr_seen", 32'(wq.size()), 32'd0);
  endtask

  task automatic rd_chk(input logic [4:0] a, input logic [31:0] exp);
    rd_req = 1'b1; rd_addr = a;
    @(posedge clk); #1;
    rd_req = 1'b0;
    chk("rd_valid_early", {31'd0, rd_valid}, 32'd0);
    @(posedge clk); #1;
    chk("rd_valid", {31'd0, rd_valid}, 32'd1);
    chk($sformatf("rd_data_%0d", a), rd_data, exp);
    @(posedge clk); #1;
    chk("rd_valid_pulse", {31'd0, rd_valid}, 32'd0);
  endtask

  initial begin
    reseed_ref();
    repeat (3) @(posedge clk);
    #1;
    // Reset state
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_r3_wr", {31'd0, r3_wr}, 32'd0);
    chk("rst_r3_din", r3_din, 32'd0);
    chk("rst_rd_valid", {31'd0, rd_valid}, 32'd0);
    chk("rst_last_value", last_value, 32'd0);
    chk("rst_sat", {31'd0, sat}, 32'd0);
    chk("rst_r1_addr", {27'd0, r1_addr}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Basic fill to reg[7]: 2,3,5,8,13,21, done 13 cycles in
    do_fill(7, 1'b0);
    chk("last_value_21", last_value, 32'd21);
    rd_chk(5'd5, 32'd8);

    // Degenerate fill: no writes, last_value kept
    do_fill(1, 1'b0);
    chk("last_value_kept", last_value, 32'd21);

    // Overflow on reg[2]
    host_wr(5'd0, 32'h8000_0000);
    host_wr(5'd1, 32'h8000_0000);
    do_fill(2, 1'b0);
`ifdef FIB_SAT_EN
    rd_chk(5'd2, 32'hFFFF_FFFF);
`else
    rd_chk(5'd2, 32'h0000_0000);
`endif
    chk("sat_sticky", {31'd0, sat}, {31'd0, exp_sat});

    // Full fill with requests pulsed mid-fill
    host_wr(5'd0, 32'd1);
    host_wr(5'd1, 32'd1);
    do_fill(31, 1'b1);
    rd_chk(5'd31, 32'h0021_3D05);
    rd_chk(5'd4, ref_mem[4]);

    // Reset during FWR of a fill to reg[10]
    ref_fill(10);
    start = 1'b1; n_last = 5'd10;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("pre_abort_in_fwr", {31'd0, r3_wr}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("abort_r3_wr", {31'd0, r3_wr}, 32'd0);
    chk("abort_r3_din", r3_din, 32'd0);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_last_value", last_value, 32'd0);
    chk("abort_r3_addr", {27'd0, r3_addr}, 32'd0);
    chk("abort_writes_done", 32'(wq.size()), 32'd7);
    wq.delete();
    reseed_ref();
    exp_last = '0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    do_fill(3, 1'b0);
    rd_chk(5'd3, 32'd3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
